// File: rtl/vm1_bus_pkg.sv
// Shared definitions for the VM1 bus responder: FSM states, decode targets,
// captured-request record and console register defaults.
package vm1_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ACCESS, ST_WAIT, ST_REPLY, ST_HOLD, ST_IGNORE
  } state_t;

  typedef enum logic [1:0] {TGT_RAM, TGT_TPS, TGT_TPB} tgt_t;

  typedef struct packed {
    logic       a0;
    logic       wtbt;
    logic       wr;
    tgt_t       tgt;
    logic [7:0] wbyte;
  } bus_req_t;

  localparam logic [15:0] TPS_ADDR_DEF = 16'o177564;
  localparam logic [15:0] TPB_ADDR_DEF = 16'o177566;
  localparam int          TPS_RDY_BIT  = 7;

  function automatic logic [1:0] byte_en(input logic wtbt, input logic a0);
    return !wtbt ? 2'b11 : (a0 ? 2'b10 : 2'b01);
  endfunction

endpackage

// File: rtl/vm1_console_tx.sv
// Console transmit holding register with valid/ready handoff and TPS status word.
module vm1_console_tx
  import vm1_bus_pkg::*;
(
  input  logic        mclk,
  input  logic        mreset_n,
  input  logic        load,
  input  logic [7:0]  load_data,
  input  logic        tx_ready_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  output logic [15:0] status_o
);

  always_ff @(posedge mclk or negedge mreset_n) begin
    if (!mreset_n) begin
      tx_data_o  <= '0;
      tx_valid_o <= 1'b0;
    end else if (load) begin
      tx_data_o  <= load_data;
      tx_valid_o <= 1'b1;
    end else if (tx_valid_o && tx_ready_i) begin
      tx_valid_o <= 1'b0;
    end
  end

  always_comb begin
    status_o              = '0;
    status_o[TPS_RDY_BIT] = ~tx_valid_o;
  end

endmodule

// File: rtl/vm1_bus_responder.sv
// VM1 bus slave: decodes SYNC/DIN/DOUT cycles onto a word RAM port and the
// console TPS/TPB pair, and answers with a registered RPLY.
module vm1_bus_responder
  import vm1_bus_pkg::*;
#(
  parameter int          RAM_AW      = 15,
  parameter int          WAIT_STATES = 0,
  parameter logic [15:0] TPS_ADDR    = TPS_ADDR_DEF,
  parameter logic [15:0] TPB_ADDR    = TPB_ADDR_DEF
) (
  input  logic              mclk,
  input  logic              mreset_n,
  input  logic              sync_i,
  input  logic              din_i,
  input  logic              dout_i,
  input  logic              wtbt_i,
  input  logic [15:0]       addr_i,
  input  logic [15:0]       data_i,
  output logic [15:0]       data_o,
  output logic              rply_o,
  output logic [RAM_AW-1:0] mem_addr_o,
  output logic              mem_rd_o,
  output logic              mem_we_o,
  output logic [1:0]        mem_be_o,
  output logic [15:0]       mem_wdata_o,
  input  logic [15:0]       mem_rdata_i,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i
);

  state_t      state;
  bus_req_t    req;
  logic [3:0]  wcnt;
  logic        rd_cap;
  logic [15:0] rdata_q;
  logic [15:0] tps_word;
  logic        hit_tps, hit_tpb, hit_ram, start, reject;
  logic        stall, tx_load;
  logic [15:0] ram_word, rd_word;

  always_comb begin
    hit_tps = {addr_i[15:1], 1'b0} == {TPS_ADDR[15:1], 1'b0};
    hit_tpb = {addr_i[15:1], 1'b0} == {TPB_ADDR[15:1], 1'b0};
    hit_ram = (32'(addr_i) >> (RAM_AW + 1)) == 32'd0;
    start   = sync_i && (din_i || dout_i);
    reject  = (din_i && dout_i) || !(hit_tps || hit_tpb || hit_ram);
  end

  // A TPB write cannot overwrite a character the sink has not yet taken.
  assign stall   = req.wr && (req.tgt == TGT_TPB) && tx_valid_o && !tx_ready_i;
  assign tx_load = (state == ST_REPLY) && sync_i && req.wr && (req.tgt == TGT_TPB);

  // RAM data is live on the port only the cycle after the read strobe.
  always_comb begin
    ram_word = rd_cap ? mem_rdata_i : rdata_q;
    rd_word  = '0;
    if (!req.wr) begin
      case (req.tgt)
        TGT_TPS: rd_word = tps_word;
        TGT_TPB: rd_word = {8'h00, tx_data_o};
        default: rd_word = !req.wtbt ? ram_word :
                           req.a0    ? {8'h00, ram_word[15:8]} : {8'h00, ram_word[7:0]};
      endcase
    end
  end

  always_ff @(posedge mclk or negedge mreset_n) begin
    if (!mreset_n) begin
      state       <= ST_IDLE;
      req         <= '0;
      wcnt        <= '0;
      rd_cap      <= 1'b0;
      rdata_q     <= '0;
      data_o      <= '0;
      rply_o      <= 1'b0;
      mem_addr_o  <= '0;
      mem_rd_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_be_o    <= '0;
      mem_wdata_o <= '0;
    end else begin
      mem_rd_o <= 1'b0;
      mem_we_o <= 1'b0;
      rd_cap   <= 1'b0;
      if (rd_cap) rdata_q <= mem_rdata_i;
      case (state)
        ST_IDLE: if (start) begin
          req.a0      <= addr_i[0];
          req.wtbt    <= wtbt_i;
          req.wr      <= dout_i;
          req.tgt     <= hit_tps ? TGT_TPS : hit_tpb ? TGT_TPB : TGT_RAM;
          req.wbyte   <= data_i[7:0];
          mem_addr_o  <= addr_i[RAM_AW:1];
          mem_be_o    <= byte_en(wtbt_i, addr_i[0]);
          mem_wdata_o <= wtbt_i ? {2{data_i[7:0]}} : data_i;
          if (reject) begin
            state <= ST_IGNORE;
          end else begin
            state    <= ST_ACCESS;
            mem_rd_o <= din_i && !hit_tps && !hit_tpb;
            mem_we_o <= dout_i && !hit_tps && !hit_tpb;
          end
        end
        ST_ACCESS: if (!sync_i) begin
          state <= ST_IDLE;
        end else begin
          rd_cap <= !req.wr && (req.tgt == TGT_RAM);
          wcnt   <= (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
          state  <= (WAIT_STATES != 0 || stall) ? ST_WAIT : ST_REPLY;
        end
        ST_WAIT: if (!sync_i) begin
          state <= ST_IDLE;
        end else if (wcnt != 4'd0) begin
          wcnt <= wcnt - 4'd1;
        end else if (!stall) begin
          state <= ST_REPLY;
        end
        ST_REPLY: if (!sync_i) begin
          state <= ST_IDLE;
        end else begin
          rply_o <= 1'b1;
          data_o <= rd_word;
          state  <= ST_HOLD;
        end
        ST_HOLD: if (!sync_i) begin
          rply_o <= 1'b0;
          data_o <= '0;
          state  <= ST_IDLE;
        end
        ST_IGNORE: if (!sync_i) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  vm1_console_tx u_con (
    .mclk       (mclk),
    .mreset_n   (mreset_n),
    .load       (tx_load),
    .load_data  (req.wbyte),
    .tx_ready_i (tx_ready_i),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .status_o   (tps_word)
  );

endmodule

// File: doc/vm1_bus_responder.md
Name: vm1_bus_responder

Overview:
- Synthesizable bus slave for the VM1 (PDP-11) CPU bus handshake (SYNC/DIN/DOUT/WTBT/RPLY).
- Decodes each CPU cycle, drives a synchronous word RAM port and a console transmit register pair (TPS 177564 / TPB 177566), and returns RPLY.
- Sits between the CPU top and board memory/UART; replaces the behavioural memory model used in simulation.

Parameters:
RAM_AW, 15, word-address width; RAM occupies bytes 0 .. 2*2^RAM_AW-1.
WAIT_STATES, 0, extra clocks inserted before RPLY on every decoded access (0..15).
TPS_ADDR, 16'o177564, console status register address.
TPB_ADDR, 16'o177566, console transmit buffer address.

Ports:
mclk  in  1  system clock
mreset_n  in  1  asynchronous active-low reset
sync_i  in  1  CPU SYNC; address valid while high
din_i  in  1  CPU read strobe
dout_i  in  1  CPU write strobe
wtbt_i  in  1  byte access qualifier
addr_i  in  16  byte address
data_i  in  16  CPU write data (byte writes carry the byte in [7:0])
data_o  out  16  read data to CPU
rply_o  out  1  reply to CPU
mem_addr_o  out  RAM_AW  RAM word address
mem_rd_o  out  1  RAM read strobe; mem_rdata_i valid the following cycle
mem_we_o  out  1  RAM write strobe
mem_be_o  out  2  byte enables {hi,lo}
mem_wdata_o  out  16  RAM write data
mem_rdata_i  in  16  RAM read data
tx_data_o  out  8  console character
tx_valid_o  out  1  character pending
tx_ready_i  in  1  sink accepts character (transfer when valid & ready)

Behaviour:
- Reset (async, mreset_n low): state IDLE; rply_o, mem_rd_o, mem_we_o, tx_valid_o = 0; data_o, mem_*, tx_data_o = 0; wait counter 0.
- States: IDLE, ACCESS, WAIT, REPLY, HOLD, IGNORE.
- IDLE: at edge E0 where sync_i & (din_i ^ dout_i) is sampled, latch addr, wtbt, data_i, direction; decode.
  - Decoded (RAM, TPS, TPB) -> ACCESS. Undecoded, or din_i & dout_i both high -> IGNORE (no RPLY, so the CPU times out).
- ACCESS, one cycle: RAM read pulses mem_rd_o; RAM write pulses mem_we_o.
  - mem_be_o = 2'b11 for word access; for byte access, addr[0]=0 -> 01 and addr[0]=1 -> 10.
  - Byte writes replicate data_i[7:0] into both lanes of mem_wdata_o.
- WAIT counts WAIT_STATES cycles (skipped if 0). Then -> REPLY.
- REPLY, data_o loaded from captured source:
  - Word read: full word.
  - Byte read: selected byte zero-extended into [7:0].
  - TPS: bit7 = ~tx_valid_o, other bits 0.
  - TPB read: {8'h0, tx_data_o}.
- rply_o registered high; first high cycle is E0+2+WAIT_STATES.
- TPB write: if tx_valid_o is already high, hold in WAIT (RPLY withheld) until the pending char transfers. Then load tx_data_o = data_i[7:0] and set tx_valid_o, on both word and byte writes.
- tx_valid_o clears on the edge where tx_valid_o & tx_ready_i is high.
- HOLD/REPLY: rply_o stays high until sync_i is sampled low. rply_o is cleared at that edge, data_o returns to 0, and the state returns to IDLE. A new cycle cannot start the same cycle RPLY drops.
- IGNORE: wait for sync_i low -> IDLE.
- sync_i drops before REPLY (abort): return to IDLE with no RPLY. A RAM write already strobed is not undone; a pending TPB load is cancelled.
- TPS/TPB writes to TPS are accepted (RPLY) and discarded.
- Address compare is on full 16 bits for TPS/TPB, ignoring addr[0]. RAM hit requires addr[15:RAM_AW+1]==0.

Decomposition:
- Shared package vm1_bus_pkg: state encoding, TPS/TPB default addresses, TPS ready bit index (7).
- One natural sub-module: vm1_console_tx (TPB holding register, valid/ready handshake, TPS status). The FSM and decode stay in vm1_bus_responder.

Test Plan:
- Word read, 000200 holding 012737, WAIT_STATES=0: mem_rd_o at E0+1, rply_o high at E0+2, data_o=012737. rply_o drops the edge after sync_i falls.
- Byte write 0x41 to 000201, then byte read 000201: mem_be_o=10, mem_wdata_o=4141; read returns 000101. Byte read at 000200 returns its original low byte unchanged.
- WAIT_STATES=3, word write 000400=177777: mem_we_o one pulse; rply_o first high at E0+5.
- Console: write 0x48 to TPB with tx_ready_i=0, read TPS -> 000000. Second TPB write 0x49 stalls RPLY until tx_ready_i=1 for one cycle, then rply_o rises and tx_data_o=0x49. TPS reads 000200 after 0x49 is taken.
- Read of unmapped 160000 with RAM_AW=14: no rply_o for 100 cycles. After sync_i falls the FSM accepts the next read normally.
- Assert mreset_n=0 while rply_o is high: rply_o, tx_valid_o, and strobes go 0 immediately. After release, a word read completes at E0+2.
